// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, function codes, ALU ops, FSM states and instruction decode
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef enum logic [3:0] {
        I_ADD, I_SUB, I_AND, I_OR, I_SLT,
        I_LW, I_SW, I_BEQ, I_ADDI, I_J, I_BAD
    } instr_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Anything not explicitly recognised decodes to I_BAD so the core halts on it.
    function automatic instr_e decode(input logic [31:0] ir);
        instr_e r;
        r = I_BAD;
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    FN_ADD:  r = I_ADD;
                    FN_SUB:  r = I_SUB;
                    FN_AND:  r = I_AND;
                    FN_OR:   r = I_OR;
                    FN_SLT:  r = I_SLT;
                    default: r = I_BAD;
                endcase
            end
            OP_J:    r = I_J;
            OP_BEQ:  r = I_BEQ;
            OP_ADDI: r = I_ADDI;
            OP_LW:   r = I_LW;
            OP_SW:   r = I_SW;
            default: r = I_BAD;
        endcase
        return r;
    endfunction

    // Address computation for lw/sw/addi reuses the adder.
    function automatic alu_op_e alu_sel(input instr_e i);
        alu_op_e r;
        r = ALU_ADD;
        case (i)
            I_SUB:   r = ALU_SUB;
            I_AND:   r = ALU_AND;
            I_OR:    r = ALU_OR;
            I_SLT:   r = ALU_SLT;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_multicycle_cpu_if.sv
// mips_multicycle_cpu_if: single shared instruction/data memory bus with req/ready handshake
interface mips_multicycle_cpu_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mc_alu.sv
// mc_alu: combinational ALU, wrapping arithmetic and signed set-less-than
module mc_alu
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    // Select the result for the requested operation.
    always_comb begin
        y = a + b;
        case (op)
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_cpu.sv
// mips_multicycle_cpu: multicycle MIPS subset core sharing one memory port for fetch and data
module mips_multicycle_cpu
    import mips_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mips_multicycle_cpu_if.master        mem,
    output logic [XLEN-1:0]              dbg_pc,
    output logic [31:0]                  dbg_instr,
    output logic [2:0]                   dbg_state,
    output logic                         halted
);

    localparam int RW = $clog2(NREG);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] imm_q, imm_d, tgt_q, tgt_d;
    logic [XLEN-1:0] alu_q, alu_d, mdr_q, mdr_d;
    logic [XLEN-1:0] rf_q [NREG];

    logic            rf_we;
    logic [RW-1:0]   rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic [RW-1:0]   rs, rt, rd;
    instr_e          ins;
    alu_op_e         alu_op;
    logic            is_r;
    logic [XLEN-1:0] alu_y;
    logic            acc_done;

    assign ins    = decode(ir_q);
    assign alu_op = alu_sel(ins);
    assign is_r   = ins inside {I_ADD, I_SUB, I_AND, I_OR, I_SLT};
    assign rs     = ir_q[21 +: RW];
    assign rt     = ir_q[16 +: RW];
    assign rd     = ir_q[11 +: RW];

    mc_alu #(.XLEN(XLEN)) u_alu (
        .op (alu_op),
        .a  (a_q),
        .b  (is_r ? b_q : imm_q),
        .y  (alu_y)
    );

    // Request is gated by rst_n so reset drops it at once even though reset parks the FSM in FETCH.
    assign mem.mem_req   = rst_n && (state_q == S_FETCH || state_q == S_MEM);
    assign mem.mem_we    = state_q == S_MEM && ins == I_SW;
    assign mem.mem_addr  = state_q == S_MEM ? {alu_q[XLEN-1:2], 2'b00} : pc_q;
    assign mem.mem_wdata = b_q;
    assign acc_done      = mem.mem_req && mem.mem_ready;

    assign dbg_pc    = pc_q;
    assign dbg_instr = ir_q;
    assign dbg_state = state_q;
    assign halted    = state_q == S_HALT;

    // Next-state and datapath updates for each FSM phase.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        tgt_d   = tgt_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        rf_we   = 1'b0;
        rf_wa   = is_r ? rd : rt;
        rf_wd   = ins == I_LW ? mdr_q : alu_q;
        case (state_q)
            S_FETCH: begin
                if (acc_done) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rs == '0 ? {XLEN{1'b0}} : rf_q[rs];
                b_d     = rt == '0 ? {XLEN{1'b0}} : rf_q[rt];
                imm_d   = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
                tgt_d   = pc_q + {imm_d[XLEN-3:0], 2'b00};
                state_d = ins == I_BAD ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                alu_d = alu_y;
                if (ins == I_BEQ && a_q == b_q)
                    pc_d = tgt_q;
                if (ins == I_J)
                    pc_d = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
                state_d = ins inside {I_BEQ, I_J} ? S_FETCH :
                          ins inside {I_LW, I_SW} ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (acc_done) begin
                    mdr_d   = mem.mem_rdata;
                    state_d = ins == I_LW ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                rf_we   = rf_wa != '0;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // FSM and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            tgt_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            tgt_q   <= tgt_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    // Register file write port; register 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

endmodule
